// File: rtl/outfifo16_ser_if.sv
// Write-side and byte-bus signals of the 16-bit-word to 8-bit-byte output serializer.
// The slave modport is the serializer; the master modport is the writer plus byte-bus sink.
interface outfifo16_ser_if #(
  parameter int AW = 4
);
  logic [15:0] wr_data;
  logic        wr_en;
  logic        fifo_full;
  logic        fifo_afull;
  logic [AW:0] fifo_count;
  logic        en;
  logic [7:0]  dtout;
  logic        dtout_valid;
  logic        byte_hi;

  modport slave (
    input  wr_data, wr_en, en,
    output fifo_full, fifo_afull, fifo_count, dtout, dtout_valid, byte_hi
  );

  modport master (
    output wr_data, wr_en, en,
    input  fifo_full, fifo_afull, fifo_count, dtout, dtout_valid, byte_hi
  );
endinterface

// File: rtl/outfifo16_ser.sv
// Word FIFO feeding a byte serializer: low byte on phase-0 edges, high byte on phase-1 edges.
// The phase runs freely from reset so downstream byte counters stay word-aligned.
module outfifo16_ser #(
  parameter int          AW       = 4,
  parameter int          AF_LEVEL = 12,
  parameter logic [15:0] FILL     = 16'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  outfifo16_ser_if.slave     bus,
  output logic               ovf,
  output logic [15:0]        udr_cnt,
  input  logic               clr_stat
);
  localparam int          DEPTH     = 2 ** AW;
  localparam logic [AW:0] DEPTH_C   = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AF_C      = (AW + 1)'(AF_LEVEL);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [15:0]    mem [DEPTH];
  logic [15:0]    rd_word;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           full_q, full_d, afull_q, afull_d;
  logic           phase_q;
  logic [7:0]     dtout_q, dtout_d, hold_q, hold_d;
  logic           valid_q, valid_d, byte_hi_q;
  logic           ovf_q, ovf_d;
  logic [15:0]    udr_q, udr_d;
  logic           wr_ok, pop;

  assign rd_word = mem[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dtout_d  = dtout_q;
    hold_d   = hold_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    udr_d    = udr_q;
    pop      = 1'b0;
    // A full FIFO drops the write even if a pop frees a slot in the same cycle.
    wr_ok    = bus.wr_en && (count_q < DEPTH_C);

    if (!phase_q) begin
      state_d = bus.en ? RUN : IDLE;
      if (state_d == RUN && count_q != '0) begin
        pop     = 1'b1;
        dtout_d = rd_word[7:0];
        hold_d  = rd_word[15:8];
        valid_d = 1'b1;
      end else begin
        dtout_d = FILL[7:0];
        hold_d  = FILL[15:8];
        valid_d = 1'b0;
        if (state_d == RUN && udr_q != 16'hFFFF) udr_d = udr_q + 16'd1;
      end
    end else begin
      dtout_d = hold_q;
    end

    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_ok && !pop)      count_d = count_q + 1'b1;
    else if (!wr_ok && pop) count_d = count_q - 1'b1;

    if (bus.wr_en && !wr_ok) ovf_d = 1'b1;
    if (clr_stat) begin
      ovf_d = 1'b0;
      udr_d = '0;
    end

    full_d  = (count_d == DEPTH_C);
    afull_d = (count_d >= AF_C);
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      afull_q   <= 1'b0;
      phase_q   <= 1'b0;
      dtout_q   <= 8'h00;
      hold_q    <= 8'h00;
      valid_q   <= 1'b0;
      byte_hi_q <= 1'b0;
      ovf_q     <= 1'b0;
      udr_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      afull_q   <= afull_d;
      phase_q   <= ~phase_q;
      dtout_q   <= dtout_d;
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      byte_hi_q <= phase_q;
      ovf_q     <= ovf_d;
      udr_q     <= udr_d;
    end
  end

  assign bus.fifo_count  = count_q;
  assign bus.fifo_full   = full_q;
  assign bus.fifo_afull  = afull_q;
  assign bus.dtout       = dtout_q;
  assign bus.dtout_valid = valid_q;
  assign bus.byte_hi     = byte_hi_q;
  assign ovf             = ovf_q;
  assign udr_cnt         = udr_q;
endmodule
